// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide unit:
//             operation encodings, FSM state enumeration and default width.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int MD_WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_e;

    // MULT and DIV treat their operands as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : md_div_step
//  Purpose  : One combinational restoring-division iteration. The partial
//             remainder is shifted left taking in the next dividend bit (MSB
//             of quo_i), a trial subtraction of the divisor decides the new
//             quotient bit, and the remainder is restored when it borrows.
//  Ports    : rem_i     - partial remainder
//             quo_i     - dividend bits still to consume / quotient so far
//             divisor_i - divisor magnitude
//             rem_o     - updated partial remainder
//             quo_o     - quo_i shifted left with new quotient bit in LSB
//  Revision : 1.0  initial release
// ============================================================================
module md_div_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_borrow;
    logic             w_unused_diff_bit;

    assign w_shift  = {rem_i, quo_i[WIDTH-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, divisor_i};
    assign w_borrow = w_diff[WIDTH+1];

    // On success the difference is below the divisor, so bit WIDTH is zero;
    // on borrow the shifted value was below the divisor, so it fits too.
    assign w_unused_diff_bit = w_diff[WIDTH];

    assign rem_o = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~w_borrow};

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative HI/LO multiply/divide unit. Radix-2 shift-add
//             multiplication and restoring division, one bit per cycle on
//             operand magnitudes, with sign correction in a final FIX cycle.
//  Ports    : clk   - clock, rising edge
//             rst   - asynchronous active-high reset
//             start - request strobe
//             op    - MULT/MULTU/DIV/DIVU/MTHI/MTLO (6-7 no-op)
//             a, b  - operands (a is also MTHI/MTLO data)
//             busy  - arithmetic operation in progress (WIDTH+1 cycles)
//             done  - one-cycle pulse after hi/lo receive a new result
//             hi,lo - HI/LO result registers
//  Revision : 1.0  initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;       // negate product / quotient
    logic             rneg_q, rneg_d;     // negate remainder (dividend sign)
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d; // product high half / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d; // multiplier bits / quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic             w_signed_op;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_signed_op = is_signed_op(op);
    assign w_a_mag     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_b_mag     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Shift-add: add the multiplicand when the current multiplier bit is
    // set, then shift the (WIDTH+1)-bit sum and the multiplier right as one.
    assign w_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, bmag_q} : '0);

    md_div_step #(
        .WIDTH     (WIDTH)
    ) u_div_step (
        .rem_i     (acc_hi_q),
        .quo_i     (acc_lo_q),
        .divisor_i (bmag_q),
        .rem_o     (w_div_rem),
        .quo_o     (w_div_quo)
    );

    assign w_prod     = {acc_hi_q, acc_lo_q};
    assign w_prod_fix = neg_q ? -w_prod : w_prod;
    // A zero divisor produces an all-ones quotient magnitude; it must stay
    // all ones regardless of operand signs. The remainder is |a| and the
    // dividend-sign correction turns it back into a exactly.
    assign w_quo_fix  = (bmag_q == '0) ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
    assign w_rem_fix  = rneg_q ? -acc_hi_q : acc_hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bmag_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bmag_q   <= bmag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bmag_d   = bmag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        // Multiply and divide share the same start-up:
                        // upper accumulator cleared, |a| in the lower half.
                        state_d  = CALC;
                        cnt_d    = '0;
                        is_div_d = op[1];
                        neg_d    = w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rneg_d   = w_signed_op & a[WIDTH-1];
                        bmag_d   = w_b_mag;
                        acc_hi_d = '0;
                        acc_lo_d = w_a_mag;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = w_div_rem;
                    acc_lo_d = w_div_quo;
                end else begin
                    acc_hi_d = w_sum[WIDTH:1];
                    acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = w_rem_fix;
                    lo_d = w_quo_fix;
                end else begin
                    hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = w_prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Self-checking bench for mult_div_unit (WIDTH=32). Expected
//             HI/LO results come from a plain-arithmetic reference model and
//             are queued at issue time; a monitor pops and compares them on
//             every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_req;
    logic [W-1:0]   m_hi;
    logic [W-1:0]   m_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference: {hi, lo} from ordinary integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint px, py;
        int     sx, sy;
        case (o)
            OP_MULT: begin
                px = longint'($signed(x));
                py = longint'($signed(y));
                return 64'(px * py);
            end
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_DIV: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sx = x;
                sy = y;
                return {32'(sx % sy), 32'(sx / sy)};
            end
            OP_DIVU: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h required no done pulse", hi, lo);
            end else begin
                mon_req = exp_q.pop_front();
                check("done_result", {hi, lo}, mon_req);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the sampling edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int already);
        int n;
        bit hold_bad;
        n        = already;
        hold_bad = 1'b0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (hi !== m_hi || lo !== m_lo) hold_bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check({name, "_busy_cycles"}, 64'(n), 64'd33);
        check({name, "_hold"}, 64'(hold_bad), 64'd0);
        check({name, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic run_arith(input string name, input logic [2:0] o, input logic [31:0] x,
                             input logic [31:0] y);
        logic [63:0] r;
        r = ref_model(o, x, y);
        exp_q.push_back(r);
        issue(o, x, y);
        wait_idle(name, 0);
        m_hi = r[63:32];
        m_lo = r[31:0];
    endtask

    task automatic run_mt(input string name, input logic [2:0] o, input logic [31:0] x);
        issue(o, x, 32'h0);
        if (o == OP_MTHI) m_hi = x;
        if (o == OP_MTLO) m_lo = x;
        check({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_nodone"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        int          sel;

        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        m_hi  = '0;
        m_lo  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'h0);
        rst = 1'b0;

        // Directed vectors, first one issued right after reset release.
        run_arith("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_arith("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_arith("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_arith("divu_zero", OP_DIVU, 32'd7, 32'd0);
        check("divu_zero_const", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
        run_arith("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_arith("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_arith("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE);

        // Start while busy is ignored; MTHI in the done cycle is accepted.
        exp_q.push_back(64'h0000_0000_0000_000C);
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        issue(OP_DIVU, 32'd9, 32'd2);
        wait_idle("ignored_start", 5);
        m_hi = 32'h0;
        m_lo = 32'hC;
        run_mt("mthi_done_cycle", OP_MTHI, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        check("mthi_busy_stays_low", 64'(busy), 64'd0);

        // Reset in the middle of a division aborts it without a done pulse.
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #2;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'h0);
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk);
        #1;
        run_arith("divu_after_rst", OP_DIVU, 32'd100, 32'd7);
        check("divu_after_rst_const", {hi, lo}, 64'h0000_0002_0000_000E);

        // Randomized traffic, including no-op codes and operand corners.
        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            rx  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       ry = 32'h0;
                1:       ry = 32'hFFFF_FFFF;
                2:       ry = 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) rx = 32'h8000_0000;
            if (ro <= OP_DIVU) run_arith("rand_arith", ro, rx, ry);
            else               run_mt("rand_misc", ro, rx);
        end

        repeat (40) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand and HI/LO width (even, at least 8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request strobe, sampled on the clk edge.
REQ-005 The block SHALL have port op, input, 3, operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6-7 are no-op.
REQ-006 The block SHALL have port a, input, WIDTH, operand A: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 The block SHALL have port b, input, WIDTH, operand B: multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1, high while an arithmetic operation is in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking new HI/LO after an arithmetic operation.
REQ-010 The block SHALL have port hi, output, WIDTH, HI register.
REQ-011 The block SHALL have port lo, output, WIDTH, LO register.

Function
REQ-012 A start with busy=0 and op in 0-3 SHALL latch a, b and op, then enter CALC.
REQ-013 The FSM SHALL have states IDLE, CALC and FIX: IDLE->CALC on accepted start; CALC->FIX after exactly WIDTH iterations; FIX->IDLE unconditionally.
REQ-014 busy SHALL be high in CALC and FIX, i.e. exactly WIDTH+1 cycles after the accepting edge.
REQ-015 hi/lo SHALL be written on the FIX->IDLE edge, and done SHALL be high for exactly the following cycle.
REQ-016 hi/lo SHALL hold their previous values while busy=1.
REQ-017 Multiplication SHALL be radix-2 shift-add, one bit per CALC cycle; {hi,lo} = full 2*WIDTH-bit product.
REQ-018 Signed operations (MULT/DIV) SHALL operate on magnitudes, with sign correction applied in FIX.
REQ-019 Division SHALL be restoring, one quotient bit per CALC cycle: lo = quotient, hi = remainder.
REQ-020 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-021 For divisor 0 (DIV or DIVU), the block SHALL run full latency with lo = all ones and hi = a.
REQ-022 Signed DIV of the most-negative value by -1 SHALL give lo = most-negative value and hi = 0.
REQ-023 A start while busy=1 SHALL be ignored entirely; there is no queueing and in-flight state is unaffected.
REQ-024 A start with busy=0 and op MTHI/MTLO SHALL write a into hi/lo on that edge, with no busy and no done.
REQ-025 A start in the done cycle SHALL be accepted, because busy=0 in that cycle.
REQ-026 op codes 6-7 SHALL have no effect.

Reset
REQ-027 rst high SHALL asynchronously force state to IDLE and clear busy, done, hi, lo, the iteration counter and all operand/partial registers.
REQ-028 rst during CALC/FIX SHALL abort the operation, and no done pulse SHALL follow.
REQ-029 After rst is released, the first start SHALL be accepted on the next clk edge.

Structure
REQ-030 A shared package SHALL hold the op encodings, the FSM state enum (IDLE, CALC, FIX) and the WIDTH default.
REQ-031 The iteration counter SHALL be $clog2(WIDTH)+1 bits, with a terminal count of WIDTH-1.
REQ-032 One sub-module SHALL exist: md_div_step, a combinational restoring iteration (shift remainder, trial subtract, quotient bit).
REQ-033 All other logic, including the multiply step, SHALL stay in mult_div_unit.

Verification (WIDTH=32)
REQ-034 MULT, a=FFFFFFFD (-3), b=5 -> after 33 busy cycles, done pulse, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-035 MULTU, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-036 DIV, a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=0 -> lo=FFFFFFFF, hi=00000007.
REQ-037 MULTU 3*4 started, second start (DIVU 9/2) at busy cycle 5 -> ignored; result hi=0, lo=0000000C; then MTHI a=12345678 in the done cycle -> hi=12345678 on next cycle, lo unchanged, busy stays 0.
REQ-038 DIV 100/7 started, rst pulsed at busy cycle 10 -> busy=0, hi=lo=0, no done pulse; a new DIVU 100/7 then gives lo=0000000E, hi=00000002.
